// File: rtl/gray_bin_updown_counter.sv
// ---------------------------------------------------------------------------
// GrayBinUpdownCounter : gray_bin_updown_counter
//
// Purpose
//   Binary + Gray pointer counter with up/down count, synchronous load and
//   clear, and a wrap or saturate mode. The Gray value moves by exactly one
//   bit per count step, so it can be synchronised into another clock domain
//   (async FIFO pointers, credit counters).
//
// Parameters
//   N         counter width in bits (>= 2)
//   RST_VAL   binary reset/clear value (< 2**N)
//   SATURATE  0: wrap modulo 2**N, 1: hold at 2**N-1 (up) / 0 (down)
//
// Ports
//   i_clk        clock, all state on posedge
//   i_rst        synchronous active-high reset, overrides everything
//   i_clr        synchronous clear to RST_VAL
//   i_ld         load i_ld_val
//   i_ld_val     binary load value
//   i_inc        count up one
//   i_dec        count down one (i_inc & i_dec together = hold)
//   o_b          registered binary count
//   o_g          registered Gray count
//   o_bNext      combinational value o_b takes at the next edge
//   o_gNext      combinational Gray of o_bNext
//   o_at_max     registered, o_b == 2**N-1
//   o_at_min     registered, o_b == 0
//   o_wrapped    registered 1-cycle pulse after a max->0 or 0->max step
//   o_gray_err   Gray integrity checker pulse (0 unless checker built)
//
// Configuration
//   `define GRAY_BIN_COUNTER_GRAY_CHECK_EN builds the Gray integrity
//   checker; without it o_gray_err is tied low.
// ---------------------------------------------------------------------------
module gray_bin_updown_counter #(
    parameter int N        = 4,
    parameter int RST_VAL  = 0,
    parameter bit SATURATE = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_ld,
    input  logic [N-1:0] i_ld_val,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [N-1:0] o_b,
    output logic [N-1:0] o_g,
    output logic [N-1:0] o_bNext,
    output logic [N-1:0] o_gNext,
    output logic         o_at_max,
    output logic         o_at_min,
    output logic         o_wrapped,
    output logic         o_gray_err
);

    localparam logic [N-1:0] RST_B  = N'(RST_VAL);
    localparam logic [N-1:0] MAX_B  = {N{1'b1}};
    localparam logic [N-1:0] ZERO_B = '0;
    localparam logic [N-1:0] ONE_B  = N'(1);

    function automatic logic [N-1:0] bin2gray(input logic [N-1:0] x);
        return x ^ (x >> 1);
    endfunction

    logic [N-1:0] r_b;
    logic [N-1:0] r_g;
    logic         r_atMax;
    logic         r_atMin;
    logic         r_wrapped;

    logic [N-1:0] w_bNext;
    logic [N-1:0] w_gNext;
    logic         w_wrapNext;
    logic         w_stepUp;
    logic         w_stepDn;

    // Only a lone inc or a lone dec is a step; both together cancel out.
    assign w_stepUp = i_inc & ~i_dec;
    assign w_stepDn = i_dec & ~i_inc;

    // Next-value logic in priority order rst > clr > ld > step. Exposed
    // directly as o_bNext so downstream logic sees the coming value with
    // zero latency; the registers below simply capture it.
    always_comb begin
        w_bNext    = r_b;
        w_wrapNext = 1'b0;
        if (i_rst || i_clr) begin
            w_bNext = RST_B;
        end else if (i_ld) begin
            w_bNext = i_ld_val;
        end else if (w_stepUp) begin
            if (r_b == MAX_B) begin
                if (!SATURATE) begin
                    w_bNext    = ZERO_B;
                    w_wrapNext = 1'b1;
                end
            end else begin
                w_bNext = r_b + ONE_B;
            end
        end else if (w_stepDn) begin
            if (r_b == ZERO_B) begin
                if (!SATURATE) begin
                    w_bNext    = MAX_B;
                    w_wrapNext = 1'b1;
                end
            end else begin
                w_bNext = r_b - ONE_B;
            end
        end
    end

    assign w_gNext = bin2gray(w_bNext);

    // State registers. g is captured from the Gray of the next value rather
    // than re-encoded from b after the flop, so o_g is a clean register
    // output with no combinational glitching toward a synchroniser.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_b       <= RST_B;
            r_g       <= bin2gray(RST_B);
            r_atMax   <= (RST_B == MAX_B);
            r_atMin   <= (RST_B == ZERO_B);
            r_wrapped <= 1'b0;
        end else begin
            r_b       <= w_bNext;
            r_g       <= w_gNext;
            r_atMax   <= (w_bNext == MAX_B);
            r_atMin   <= (w_bNext == ZERO_B);
            r_wrapped <= w_wrapNext;
        end
    end

    assign o_b       = r_b;
    assign o_g       = r_g;
    assign o_bNext   = w_bNext;
    assign o_gNext   = w_gNext;
    assign o_at_max  = r_atMax;
    assign o_at_min  = r_atMin;
    assign o_wrapped = r_wrapped;

`ifdef GRAY_BIN_COUNTER_GRAY_CHECK_EN
    logic         r_grayErr;
    logic [N-1:0] w_gDiff;
    logic         w_moved;
    logic         w_oneHot;
    logic         w_hopBad;
    logic         w_encBad;

    // A step that actually changes the count must flip exactly one Gray
    // bit; rst/clr/ld jumps and held (saturated or inc&dec) steps are
    // legitimately excluded. x & (x-1) clears the lowest set bit, so it is
    // zero for a nonzero x only when x has a single bit set.
    assign w_gDiff  = w_gNext ^ r_g;
    assign w_moved  = ~i_rst & ~i_clr & ~i_ld & (w_stepUp | w_stepDn) & (w_bNext != r_b);
    assign w_oneHot = (w_gDiff != ZERO_B) && ((w_gDiff & (w_gDiff - ONE_B)) == ZERO_B);
    assign w_hopBad = w_moved & ~w_oneHot;
    assign w_encBad = (r_g != bin2gray(r_b));

    // Error pulse is registered so it lines up with the cycle after the
    // offending step or with the cycle after a corrupted g is observed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grayErr <= 1'b0;
        end else begin
            r_grayErr <= w_hopBad | w_encBad;
        end
    end

    assign o_gray_err = r_grayErr;
`else
    assign o_gray_err = 1'b0;
`endif

endmodule
